// File: rtl/sub_pkg.sv
// Shared types and the ripple-borrow slice function for the serial subtractor.
// The slice function works on a fixed maximum width; callers pass the live digit width.
package sub_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned MaxDigit = 64;

    // Returns {borrow_out, diff}; only the low n bits of diff are meaningful.
    function automatic logic [MaxDigit:0] rbs_slice(
        input logic [MaxDigit-1:0] a,
        input logic [MaxDigit-1:0] b,
        input logic                bin,
        input int unsigned         n
    );
        logic                br;
        logic [MaxDigit-1:0] d;
        br = bin;
        d  = '0;
        for (int unsigned i = 0; i < MaxDigit; i++) begin
            if (i < n) begin
                d[i] = a[i] ^ b[i] ^ br;
                br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
            end
        end
        return {br, d};
    endfunction

endpackage

// File: rtl/rbs_digit.sv
// Combinational DIGIT-bit ripple-borrow slice: d = a - b - bin, bout = final borrow.
module rbs_digit
    import sub_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    if (DIGIT < 1 || DIGIT >= MaxDigit) begin : gen_digit_check
        $fatal(1, "rbs_digit: DIGIT must be in 1..%0d", MaxDigit - 1);
    end

    logic [MaxDigit:0] res;
    logic              res_unused;

    always_comb begin
        res  = rbs_slice(MaxDigit'(a), MaxDigit'(b), bin, DIGIT);
        d    = res[DIGIT-1:0];
        bout = res[MaxDigit];
    end

    assign res_unused = ^res[MaxDigit-1:DIGIT];

endmodule

// File: rtl/serial_ripple_borrow_sub.sv
// Multi-cycle A - B - Bin subtractor, DIGIT bits per clock, valid/ready on both sides.
// Operands shift out LSB-first; result bits fill d_sr from the top.
module serial_ripple_borrow_sub
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy
);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gen_param_check
        $fatal(1, "serial_ripple_borrow_sub: WIDTH must be >= 1 and divisible by DIGIT");
    end

    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = $clog2(NumDigits + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sr, a_d;
    logic [WIDTH-1:0]  b_sr, b_d;
    logic [WIDTH-1:0]  d_sr, d_d;
    logic              borrow_r, borrow_d;
    logic [CntW-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]  diff_r, diff_d;
    logic              bout_r, bout_d;

    logic [DIGIT-1:0]  slice_d;
    logic              slice_bout;
    logic [WIDTH-1:0]  d_next;

    rbs_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .bin  (borrow_r),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // New digit enters at the top; after NumDigits shifts d_sr holds the full result.
    assign d_next = WIDTH'({slice_d, d_sr} >> DIGIT);

    always_comb begin
        state_d  = state_q;
        a_d      = a_sr;
        b_d      = b_sr;
        d_d      = d_sr;
        borrow_d = borrow_r;
        cnt_d    = cnt;
        diff_d   = diff_r;
        bout_d   = bout_r;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = a_sr >> DIGIT;
                b_d      = b_sr >> DIGIT;
                d_d      = d_next;
                borrow_d = slice_bout;
                cnt_d    = cnt + CntW'(1);
                if (cnt == LastCnt) begin
                    diff_d  = d_next;
                    bout_d  = slice_bout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
            diff_r   <= '0;
            bout_r   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr     <= a_d;
            b_sr     <= b_d;
            d_sr     <= d_d;
            borrow_r <= borrow_d;
            cnt      <= cnt_d;
            diff_r   <= diff_d;
            bout_r   <= bout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign Diff      = diff_r;
    assign Bout      = bout_r;

endmodule

// File: tb/tb_serial_ripple_borrow_sub.sv
// Directed and random bench for serial_ripple_borrow_sub at DIGIT = 1, 5 and 10.
module tb_serial_ripple_borrow_sub;

    logic       clk;
    logic       rst_n     [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [9:0] A         [3];
    logic [9:0] B         [3];
    logic       Bin       [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [9:0] Diff      [3];
    logic       Bout      [3];
    logic       busy      [3];

    int checks = 0;
    int errors = 0;
    int lat [3] = '{10, 2, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_ripple_borrow_sub #(.WIDTH(10), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(A[0]), .B(B[0]), .Bin(Bin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .Diff(Diff[0]), .Bout(Bout[0]), .busy(busy[0])
    );
    serial_ripple_borrow_sub #(.WIDTH(10), .DIGIT(5)) u_d5 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(A[1]), .B(B[1]), .Bin(Bin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .Diff(Diff[1]), .Bout(Bout[1]), .busy(busy[1])
    );
    serial_ripple_borrow_sub #(.WIDTH(10), .DIGIT(10)) u_d10 (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(A[2]), .B(B[2]), .Bin(Bin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .Diff(Diff[2]), .Bout(Bout[2]), .busy(busy[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for one accept edge, then scrambles them to prove they were latched.
    task automatic start_op(input int k, input logic [9:0] a, input logic [9:0] b,
                            input logic bin);
        A[k] = a; B[k] = b; Bin[k] = bin; in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0; A[k] = ~a; B[k] = ~b; Bin[k] = ~bin;
    endtask

    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (out_valid[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset(input int k);
        rst_n[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        tick();
        rst_n[k] = 1'b1;
        checks++; if (in_ready[k] !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready k=%0d got %b exp 1", k, in_ready[k]); end
        checks++; if (out_valid[k] !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid k=%0d got %b exp 0", k, out_valid[k]); end
        checks++; if (Diff[k] !== 10'd0) begin errors++;
            $display("FAIL reset_diff k=%0d got %0d exp 0", k, Diff[k]); end
        checks++; if (Bout[k] !== 1'b0) begin errors++;
            $display("FAIL reset_bout k=%0d got %b exp 0", k, Bout[k]); end
        checks++; if (busy[k] !== 1'b0) begin errors++;
            $display("FAIL reset_busy k=%0d got %b exp 0", k, busy[k]); end
    endtask

    task automatic test_basic(input int k, input logic [9:0] a, input logic [9:0] b,
                              input logic bin, input logic [9:0] exp_d, input logic exp_b);
        int n;
        out_ready[k] = 1'b1;
        start_op(k, a, b, bin);
        checks++; if (in_ready[k] !== 1'b0) begin errors++;
            $display("FAIL basic_in_ready_drop k=%0d got %b exp 0", k, in_ready[k]); end
        wait_valid(k, n);
        checks++; if (n != lat[k]) begin errors++;
            $display("FAIL basic_latency k=%0d got %0d exp %0d", k, n, lat[k]); end
        checks++; if (Diff[k] !== exp_d) begin errors++;
            $display("FAIL basic_diff k=%0d a=%0d b=%0d bin=%b got %0d exp %0d",
                     k, a, b, bin, Diff[k], exp_d); end
        checks++; if (Bout[k] !== exp_b) begin errors++;
            $display("FAIL basic_bout k=%0d a=%0d b=%0d got %b exp %b", k, a, b, Bout[k], exp_b); end
        tick();
        checks++; if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin errors++;
            $display("FAIL basic_release k=%0d got ov=%b ir=%b exp ov=0 ir=1",
                     k, out_valid[k], in_ready[k]); end
        checks++; if (Diff[k] !== exp_d) begin errors++;
            $display("FAIL basic_diff_held k=%0d got %0d exp %0d", k, Diff[k], exp_d); end
    endtask

    task automatic test_backpressure(input int k);
        int n;
        out_ready[k] = 1'b0;
        start_op(k, 10'd555, 10'd222, 1'b1);
        wait_valid(k, n);
        checks++; if (n != lat[k]) begin errors++;
            $display("FAIL bp_latency k=%0d got %0d exp %0d", k, n, lat[k]); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Diff[k] !== 10'd332 || Bout[k] !== 1'b0 || busy[k] !== 1'b1 ||
                in_ready[k] !== 1'b0 || out_valid[k] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold k=%0d cyc=%0d got d=%0d bo=%b busy=%b ir=%b ov=%b exp d=332 bo=0 busy=1 ir=0 ov=1",
                         k, i, Diff[k], Bout[k], busy[k], in_ready[k], out_valid[k]);
            end
            if (i == 2) begin A[k] = 10'd1; B[k] = 10'd1; Bin[k] = 1'b0; in_valid[k] = 1'b1; end
            else in_valid[k] = 1'b0;
            tick();
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        tick();
        checks++; if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release k=%0d got ov=%b ir=%b busy=%b exp ov=0 ir=1 busy=0",
                     k, out_valid[k], in_ready[k], busy[k]); end
        tick();
        checks++; if (busy[k] !== 1'b0 || Diff[k] !== 10'd332) begin errors++;
            $display("FAIL bp_ignored_pulse k=%0d got busy=%b d=%0d exp busy=0 d=332",
                     k, busy[k], Diff[k]); end
    endtask

    task automatic test_abort(input int k);
        int pre;
        bit seen;
        out_ready[k] = 1'b1;
        start_op(k, 10'd217, 10'd298, 1'b0);
        pre = (lat[k] - 1 < 3) ? lat[k] - 1 : 3;
        for (int i = 0; i < pre; i++) tick();
        rst_n[k] = 1'b0;
        tick();
        rst_n[k] = 1'b1;
        checks++;
        if (out_valid[k] !== 1'b0 || Diff[k] !== 10'd0 || Bout[k] !== 1'b0 ||
            in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL abort_state k=%0d got ov=%b d=%0d bo=%b ir=%b busy=%b exp ov=0 d=0 bo=0 ir=1 busy=0",
                     k, out_valid[k], Diff[k], Bout[k], in_ready[k], busy[k]);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid[k] === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL abort_no_result k=%0d got out_valid seen=%b exp 0", k, seen); end
    endtask

    task automatic test_back_to_back(input int k);
        int n;
        out_ready[k] = 1'b1;
        A[k] = 10'd100; B[k] = 10'd1; Bin[k] = 1'b0; in_valid[k] = 1'b1;
        tick();
        wait_valid(k, n);
        checks++; if (Diff[k] !== 10'd99 || Bout[k] !== 1'b0) begin errors++;
            $display("FAIL b2b_first k=%0d got d=%0d bo=%b exp d=99 bo=0", k, Diff[k], Bout[k]); end
        A[k] = 10'd7; B[k] = 10'd9; Bin[k] = 1'b1;
        tick();
        tick();
        in_valid[k] = 1'b0;
        wait_valid(k, n);
        checks++; if (n + 2 != lat[k] + 2) begin errors++;
            $display("FAIL b2b_throughput k=%0d got %0d exp %0d", k, n + 2, lat[k] + 2); end
        checks++; if (Diff[k] !== 10'd1021 || Bout[k] !== 1'b1) begin errors++;
            $display("FAIL b2b_second k=%0d got d=%0d bo=%b exp d=1021 bo=1",
                     k, Diff[k], Bout[k]); end
        tick();
    endtask

    task automatic test_random(input int k, input int count);
        logic [9:0]  a, b;
        logic        bin;
        logic [10:0] ref_v;
        int          n;
        out_ready[k] = 1'b1;
        for (int i = 0; i < count; i++) begin
            a = 10'($urandom); b = 10'($urandom); bin = 1'($urandom);
            ref_v = {1'b0, a} - {1'b0, b} - {10'd0, bin};
            start_op(k, a, b, bin);
            wait_valid(k, n);
            checks++;
            if (n != lat[k] || Diff[k] !== ref_v[9:0] || Bout[k] !== ref_v[10]) begin
                errors++;
                $display("FAIL random k=%0d a=%0d b=%0d bin=%b got d=%0d bo=%b lat=%0d exp d=%0d bo=%b lat=%0d",
                         k, a, b, bin, Diff[k], Bout[k], n, ref_v[9:0], ref_v[10], lat[k]);
            end
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
            A[k] = '0; B[k] = '0; Bin[k] = 1'b0;
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            test_reset(k);
            test_basic(k, 10'd598, 10'd98, 1'b0, 10'd500, 1'b0);
            test_basic(k, 10'd98, 10'd598, 1'b0, 10'd524, 1'b1);
            test_basic(k, 10'd0, 10'd0, 1'b1, 10'd1023, 1'b1);
            test_basic(k, 10'd1023, 10'd0, 1'b0, 10'd1023, 1'b0);
            test_backpressure(k);
            test_abort(k);
            test_back_to_back(k);
        end
        for (int k = 0; k < 3; k++) test_random(k, 500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
